// File: rtl/slave_arb_pkg.sv
// Shared types and constants for the per-slave round-robin arbiter.
package slave_arb_pkg;

    // Master command encoding
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int unsigned DEFAULT_QTY_OF_MASTERS = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RDATA
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit at or after ptr_i,
// wrapping modulo QTY_OF_MASTERS.
module rr_arbiter
    import slave_arb_pkg::*;
#(
    parameter  int unsigned QTY_OF_MASTERS = DEFAULT_QTY_OF_MASTERS,
    localparam int unsigned IDX_W          = $clog2(QTY_OF_MASTERS)
) (
    input  logic [QTY_OF_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]          ptr_i,
    output logic [IDX_W-1:0]          idx_o,
    output logic                      valid_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest request to ptr_i wins
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = QTY_OF_MASTERS - 1; k >= 0; k--) begin
            // Power-of-two master count: natural overflow performs the wrap
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave arbiter: grants one requesting master at a time (round-robin),
// forwards its command to the slave and routes ack / read data back to it.
// Optional ack watchdog enabled by defining SLAVE_ARB_TIMEOUT_EN.
module slave_port_arbiter
    import slave_arb_pkg::*;
#(
    parameter int unsigned QTY_OF_MASTERS = DEFAULT_QTY_OF_MASTERS,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [QTY_OF_MASTERS-1:0]          request_from_listeners,
    input  logic [QTY_OF_MASTERS*ADDR_W-1:0]   master_addr,
    input  logic [QTY_OF_MASTERS-1:0]          master_cmd,
    input  logic [QTY_OF_MASTERS*DATA_W-1:0]   master_wdata,
    output logic [QTY_OF_MASTERS-1:0]          ack_to_masters,
    output logic [QTY_OF_MASTERS-1:0]          rvalid_to_masters,
    output logic [DATA_W-1:0]                  rdata_to_masters,
    output logic [QTY_OF_MASTERS-1:0]          err_to_masters,
    output logic                               slave_req,
    output logic [ADDR_W-1:0]                  slave_addr,
    output logic                               slave_cmd,
    output logic [DATA_W-1:0]                  slave_wdata,
    input  logic                               slave_ack,
    input  logic [DATA_W-1:0]                  slave_rdata
);

    localparam int unsigned IDX_W = $clog2(QTY_OF_MASTERS);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;

    // Last values shown on the data outputs, so they hold outside their state
    logic [ADDR_W-1:0]   addr_q;
    logic                cmd_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [IDX_W-1:0]          win_idx;
    logic                      win_valid;
    logic                      gnt_req;
    logic                      gnt_cmd;
    logic [ADDR_W-1:0]         gnt_addr;
    logic [DATA_W-1:0]         gnt_wdata;
    logic [QTY_OF_MASTERS-1:0] gnt_onehot;
    logic                      timeout_hit;

    rr_arbiter #(
        .QTY_OF_MASTERS (QTY_OF_MASTERS)
    ) u_rr_arbiter (
        .req_i   (request_from_listeners),
        .ptr_i   (ptr_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // Fields of the currently granted master
    always_comb begin
        gnt_req    = request_from_listeners[grant_q];
        gnt_cmd    = master_cmd[grant_q];
        gnt_addr   = master_addr[int'(grant_q)*ADDR_W +: ADDR_W];
        gnt_wdata  = master_wdata[int'(grant_q)*DATA_W +: DATA_W];
        gnt_onehot = QTY_OF_MASTERS'(1) << grant_q;
    end

`ifdef SLAVE_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count GRANT cycles; restarts from zero on every fresh grant
    always_comb begin
        cnt_d = '0;
        if (state_q == GRANT && state_d == GRANT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th GRANT cycle without an ack
    always_comb begin
        timeout_hit = (state_q == GRANT) && gnt_req && !slave_ack &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
`else
    // No watchdog: GRANT waits for the slave indefinitely
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // FSM state, grant pointer and grant index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Next-state, pointer advance and grant capture
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!gnt_req) begin
                    // Master withdrew before ack: abandon without advancing ptr
                    state_d = IDLE;
                end else if (slave_ack) begin
                    ptr_d   = grant_q + 1'b1;
                    state_d = (gnt_cmd == CMD_WRITE) ? IDLE : RDATA;
                end else if (timeout_hit) begin
                    ptr_d   = grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            RDATA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        slave_req         = 1'b0;
        ack_to_masters    = '0;
        rvalid_to_masters = '0;
        err_to_masters    = '0;
        slave_addr        = addr_q;
        slave_cmd         = cmd_q;
        slave_wdata       = wdata_q;
        rdata_to_masters  = rdata_q;
        unique case (state_q)
            GRANT: begin
                slave_req   = 1'b1;
                slave_addr  = gnt_addr;
                slave_cmd   = gnt_cmd;
                slave_wdata = gnt_wdata;
                if (gnt_req && (slave_ack || timeout_hit)) begin
                    ack_to_masters = gnt_onehot;
                end
                if (timeout_hit) begin
                    err_to_masters = gnt_onehot;
                end
            end
            RDATA: begin
                rvalid_to_masters = gnt_onehot;
                rdata_to_masters  = slave_rdata;
            end
            default: ;
        endcase
    end

    // Capture the last driven data values so they hold between transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            cmd_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == GRANT) begin
                addr_q  <= gnt_addr;
                cmd_q   <= gnt_cmd;
                wdata_q <= gnt_wdata;
            end
            if (state_q == RDATA) begin
                rdata_q <= slave_rdata;
            end
        end
    end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Scoreboard bench for slave_port_arbiter: a round-robin model predicts the
// winner of each request pattern; the bench plays the slave.
module tb_slave_port_arbiter;
    import slave_arb_pkg::*;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic              clk;
    logic              rst_n;
    logic [NM-1:0]     request_from_listeners;
    logic [NM*AW-1:0]  master_addr;
    logic [NM-1:0]     master_cmd;
    logic [NM*DW-1:0]  master_wdata;
    logic [NM-1:0]     ack_to_masters;
    logic [NM-1:0]     rvalid_to_masters;
    logic [DW-1:0]     rdata_to_masters;
    logic [NM-1:0]     err_to_masters;
    logic              slave_req;
    logic [AW-1:0]     slave_addr;
    logic              slave_cmd;
    logic [DW-1:0]     slave_wdata;
    logic              slave_ack;
    logic [DW-1:0]     slave_rdata;

    slave_port_arbiter #(
        .QTY_OF_MASTERS (NM),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .request_from_listeners (request_from_listeners),
        .master_addr            (master_addr),
        .master_cmd             (master_cmd),
        .master_wdata           (master_wdata),
        .ack_to_masters         (ack_to_masters),
        .rvalid_to_masters      (rvalid_to_masters),
        .rdata_to_masters       (rdata_to_masters),
        .err_to_masters         (err_to_masters),
        .slave_req              (slave_req),
        .slave_addr             (slave_addr),
        .slave_cmd              (slave_cmd),
        .slave_wdata            (slave_wdata),
        .slave_ack              (slave_ack),
        .slave_rdata            (slave_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];

    int          n_tests;
    int          n_fail;
    int          mptr;
    logic [31:0] m_addr[NM];
    logic [31:0] m_wdata[NM];
    logic        m_cmd[NM];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_master(input int i, input logic cmd, input logic [31:0] addr,
                              input logic [31:0] wdata);
        m_cmd[i]                  = cmd;
        m_addr[i]                 = addr;
        m_wdata[i]                = wdata;
        master_cmd[i]             = cmd;
        master_addr[i*AW +: AW]   = addr;
        master_wdata[i*DW +: DW]  = wdata;
    endtask

    function automatic int model_pick(input logic [NM-1:0] r);
        for (int k = 0; k < NM; k++) begin
            int c;
            c = (mptr + k) % NM;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    // Returns the number of negedges until slave_req is seen (bounded)
    task automatic wait_slave_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!slave_req && n < 20);
        check_eq("slave_req_wait", 64'(slave_req), 64'd1);
    endtask

    task automatic run_txn(input logic [NM-1:0] reqv, input int waits,
                           input logic [31:0] rd, input bit drop, output int lat);
        exp_t e;
        int   w;
        w       = model_pick(reqv);
        e.m     = w;
        e.cmd   = m_cmd[w];
        e.addr  = m_addr[w];
        e.wdata = m_wdata[w];
        exp_q.push_back(e);
        request_from_listeners = reqv;
        wait_slave_req(lat);
        for (int i = 0; i < waits; i++) begin
            check_eq("ack_held_off", 64'(ack_to_masters), 64'd0);
            @(negedge clk);
        end
        slave_ack = 1'b1;
        #1;
        e = exp_q.pop_front();
        check_eq("ack_onehot", 64'(ack_to_masters), 64'(1 << e.m));
        check_eq("slave_addr", 64'(slave_addr), 64'(e.addr));
        check_eq("slave_cmd", 64'(slave_cmd), 64'(e.cmd));
        if (e.cmd == CMD_WRITE) check_eq("slave_wdata", 64'(slave_wdata), 64'(e.wdata));
        check_eq("err_idle", 64'(err_to_masters), 64'd0);
        mptr = (e.m + 1) % NM;
        @(posedge clk);
        #1;
        slave_ack = 1'b0;
        if (drop) request_from_listeners = '0;
        if (e.cmd == CMD_READ) begin
            slave_rdata = rd;
            rd_q.push_back(rd);
            @(negedge clk);
            check_eq("rvalid_onehot", 64'(rvalid_to_masters), 64'(1 << e.m));
            check_eq("rdata", 64'(rdata_to_masters), 64'(rd_q.pop_front()));
            check_eq("ack_in_rdata", 64'(ack_to_masters), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        n_tests = 0;
        n_fail  = 0;
        mptr    = 0;
        rst_n   = 1'b0;
        request_from_listeners = '0;
        master_addr  = '0;
        master_cmd   = '0;
        master_wdata = '0;
        slave_ack    = 1'b0;
        slave_rdata  = '0;
        set_master(0, CMD_WRITE, 32'h0000_1000, 32'h1111_0000);
        set_master(1, CMD_READ,  32'h0000_2000, 32'h0);
        set_master(2, CMD_WRITE, 32'h0000_0010, 32'hA5A5_0001);
        set_master(3, CMD_WRITE, 32'h0000_3000, 32'h3333_0003);

        // Reset, then ten idle cycles with no requests
        #12;
        check_eq("reset_outs", 64'({slave_req, ack_to_masters, rvalid_to_masters,
                 err_to_masters}), 64'd0);
        check_eq("reset_data", 64'({slave_addr, rdata_to_masters}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_outs", 64'({slave_req, ack_to_masters, rvalid_to_masters,
                     err_to_masters}), 64'd0);
        end

        // Master 2 write, acked on the first GRANT cycle; slave_req at N+1
        @(posedge clk);
        #1;
        run_txn(4'b0100, 0, 32'h0, 1'b1, lat);
        check_eq("req_latency", 64'(lat), 64'd2);
        // Pointer now at 3: master 3 beats masters 0 and 2
        run_txn(4'b1101, 0, 32'h0, 1'b1, lat);
        // Master 1 read with 3 wait cycles
        run_txn(4'b0010, 3, 32'hDEAD_BEEF, 1'b1, lat);
        // Master 3 write brings the pointer back to 0
        run_txn(4'b1000, 0, 32'h0, 1'b1, lat);
        // All masters requesting: rotation 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) begin
            run_txn(4'b1111, 0, 32'h0, (i == 5), lat);
        end
        // Master 0 write sets pointer to 1, then 1001 grants 3 then 0
        run_txn(4'b0001, 0, 32'h0, 1'b1, lat);
        run_txn(4'b1001, 0, 32'h0, 1'b0, lat);
        run_txn(4'b1001, 0, 32'h0, 1'b1, lat);

        // Granted master withdraws before ack: no ack, pointer unchanged
        request_from_listeners = 4'b0010;
        wait_slave_req(lat);
        request_from_listeners = 4'b0000;
        #1;
        check_eq("withdraw_no_ack", 64'(ack_to_masters), 64'd0);
        @(negedge clk);
        check_eq("withdraw_idle", 64'(slave_req), 64'd0);
        run_txn(4'b0011, 0, 32'h0, 1'b1, lat);

`ifdef SLAVE_ARB_TIMEOUT_EN
        // Slave never acks master 0: error pulse on the 16th GRANT cycle
        request_from_listeners = 4'b0001;
        wait_slave_req(lat);
        for (int c = 1; c < TO; c++) begin
            check_eq("err_early", 64'(err_to_masters), 64'd0);
            @(negedge clk);
        end
        check_eq("timeout_err", 64'(err_to_masters), 64'd1);
        check_eq("timeout_ack", 64'(ack_to_masters), 64'd1);
        mptr = 1;
        @(posedge clk);
        #1;
        request_from_listeners = '0;
        check_eq("timeout_req_drop", 64'(slave_req), 64'd0);
`endif

        // Asynchronous reset during GRANT
        @(posedge clk);
        #1;
        request_from_listeners = 4'b0001;
        wait_slave_req(lat);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_req", 64'(slave_req), 64'd0);
        check_eq("async_rst_ack", 64'(ack_to_masters), 64'd0);
        @(posedge clk);
        #1;
        request_from_listeners = '0;
        rst_n = 1'b1;
        mptr  = 0;
        run_txn(4'b1111, 0, 32'h0, 1'b1, lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slave_port_arbiter.md
# slave_port_arbiter

Per-slave arbiter at the slave end of the master→slave request path. It collects the one-hot requests that the per-master address decoders raise toward this slave and grants one master at a time, round-robin. It forwards the granted master's command to the slave, then routes the slave's ack and read data back to that master only. One instance sits in front of each slave of the crossbar.

## Interface
Parameters:
- QTY_OF_MASTERS, 4, number of requesting masters (power of two, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, ack watchdog limit (used only with SLAVE_ARB_TIMEOUT_EN)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- request_from_listeners  in  QTY_OF_MASTERS  bit i = master i targets this slave
- master_addr  in  QTY_OF_MASTERS×ADDR_W  per-master address
- master_cmd  in  QTY_OF_MASTERS  per-master command (0 read, 1 write)
- master_wdata  in  QTY_OF_MASTERS×DATA_W  per-master write data
- ack_to_masters  out  QTY_OF_MASTERS  one-hot ack to the granted master
- rvalid_to_masters  out  QTY_OF_MASTERS  one-hot read-data-valid
- rdata_to_masters  out  DATA_W  read data, shared by all masters and qualified by rvalid
- err_to_masters  out  QTY_OF_MASTERS  one-hot timeout error; tied 0 without the macro
- slave_req  out  1  request to slave
- slave_addr / slave_cmd / slave_wdata  out  ADDR_W / 1 / DATA_W  granted master's fields
- slave_ack  in  1  slave accepts the command
- slave_rdata  in  DATA_W  read data, valid the cycle after an ack of a read

## Operation
- FSM states: IDLE, GRANT, RDATA. Reset → IDLE.
- Grant pointer `ptr` resets to 0.
- IDLE:
  - If any request bit is set, rr_arbiter picks the first set bit at or after `ptr`, wrapping modulo QTY_OF_MASTERS.
  - The winner index is registered and the FSM moves to GRANT.
  - With no request bit set, the FSM stays in IDLE.
- GRANT:
  - slave_req = 1.
  - slave_addr, slave_cmd and slave_wdata are muxed from the registered grant index.
  - The grant is locked: no preemption while in GRANT.
  - slave_ack with cmd = write: ack_to_masters[g] pulses for this cycle, `ptr` ← g+1 (wraps), FSM → IDLE.
  - slave_ack with cmd = read: ack_to_masters[g] pulses, `ptr` ← g+1, FSM → RDATA.
  - Granted master drops its request before any ack (protocol violation): FSM → IDLE, no ack, `ptr` unchanged.
- RDATA:
  - rvalid_to_masters[g] = 1 for one cycle.
  - rdata_to_masters = slave_rdata, passed through combinationally.
  - FSM → IDLE.
- Outputs outside their qualifying state:
  - slave_req, ack, rvalid and err are 0.
  - Data/address outputs hold the last muxed value; their content is don't-care.
- Reset mid-transfer: all outputs drop to 0 immediately and asynchronously; the in-flight transaction is lost.

## Timing
- Request seen at cycle N → slave_req at N+1. Request seen at N means sampled on the clock edge that ends cycle N.
- Ack is combinational from slave_ack in the same cycle.
- Minimum cost per transaction:
  - Write: 2 cycles (IDLE + GRANT).
  - Read: 3 cycles (IDLE + GRANT + RDATA).
- Fairness: with all masters requesting continuously, grants rotate 0,1,2,3,0 and so on.
- Every master is served within QTY_OF_MASTERS transactions.
- The slave may hold off ack indefinitely unless the macro is enabled.

## Configuration
- SLAVE_ARB_TIMEOUT_EN defined:
  - A counter runs while in GRANT and clears on leaving GRANT.
  - When it reaches TIMEOUT_CYCLES without slave_ack, err_to_masters[g] and ack_to_masters[g] pulse together.
  - `ptr` ← g+1, FSM → IDLE.
  - slave_req drops in the following cycle.
- Not defined: no counter, err_to_masters tied to 0, GRANT waits for ack indefinitely.

## Structure
- Package slave_arb_pkg holds:
  - cmd encoding constants CMD_READ = 0, CMD_WRITE = 1
  - state enum arb_state_t {IDLE, GRANT, RDATA}
  - default QTY_OF_MASTERS
- One sub-module, rr_arbiter:
  - Purely combinational.
  - Inputs: request vector and `ptr`. Outputs: winner index and valid.
  - Its behaviour is verifiable standalone.

## Test plan
- Reset, no requests: all outputs 0, FSM stays IDLE for 10 cycles.
- Master 2 writes addr 0x10, wdata 0xA5A5_0001, slave acks on the first GRANT cycle:
  - slave_req at N+1 with those fields; ack_to_masters = 0100 in the same cycle.
  - Next write is granted starting from master 3.
- Master 1 reads, slave acks after 3 wait cycles, slave_rdata = 0xDEAD_BEEF the next cycle:
  - ack_to_masters = 0010.
  - One cycle later, rvalid_to_masters = 0010 and rdata_to_masters = 0xDEAD_BEEF.
- request_from_listeners = 1111 held, slave always acks, writes: grant order 0,1,2,3,0,1.
- Requests 1001 with `ptr` = 1: master 3 is granted first, then master 0.
- With SLAVE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, slave never acks master 0:
  - After 16 GRANT cycles, err_to_masters = ack_to_masters = 0001 for one cycle, FSM returns to IDLE.
  - Assert rst_n low during a GRANT: slave_req falls without waiting for a clock edge.
